// File: rtl/wb_io_ctrl.sv
// wb_io_ctrl: Wishbone board I/O slave (LEDs, muxed 7-seg, keypad, step buttons).
// Define IO_CTRL_KEYSCAN_EN to build the debounced 4x4 keypad scanner.

module wb_io_dbnc #(
    parameter int DEBOUNCE_W = 16
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic din,
    output logic dout
);
    logic [1:0]            sync;
    logic [DEBOUNCE_W-1:0] cnt;

    // dout follows the synchronised input only after it differs for 2^DEBOUNCE_W cycles
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) cnt <= '0;
            else if (&cnt) begin
                dout <= sync[1];
                cnt  <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

module wb_io_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int LED_W      = 16,
    parameter int SW_W       = 8,
    parameter int SCAN_DIV_W = 17,
    parameter int DEBOUNCE_W = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic [LED_W-1:0]      led,
    output logic [1:0]            led_rg0,
    output logic [1:0]            led_rg1,
    output logic [NUM_DIGITS-1:0] num_csn,
    output logic [6:0]            num_a_g,
    input  logic [SW_W-1:0]       switch,
    input  logic [3:0]            btn_key_row,
    output logic [3:0]            btn_key_col,
    input  logic [1:0]            btn_step
);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [15:0] A_LED = 16'hF000, A_RG0 = 16'hF004, A_RG1 = 16'hF008,
                            A_NLO = 16'hF010, A_NHI = 16'hF014, A_BLK = 16'hF018,
                            A_SW  = 16'hF020, A_KEY = 16'hF024, A_STP = 16'hF028;

    logic [LED_W-1:0]      led_r;
    logic [1:0]            rg0_r, rg1_r, step_r, step_db, step_db_q, step_clr;
    logic [31:0]           num_lo, num_hi, rd_data, key_rd;
    logic [NUM_DIGITS-1:0] blank_r;
    logic [SW_W-1:0]       sw_s1, sw_s2;
    logic [3:0]            row_s1, row_s2;
    logic [15:0]           adr;
    logic                  req, wr, rd, tick, unused_adr;

    assign adr        = wb_adr_i[15:0];
    assign unused_adr = ^wb_adr_i[31:16];
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr         = req & wb_we_i;
    assign rd         = req & ~wb_we_i;
    assign led        = led_r;
    assign led_rg0    = rg0_r;
    assign led_rg1    = rg1_r;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = sel[b] ? d[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E; 4'h1: return 7'h30; 4'h2: return 7'h6D; 4'h3: return 7'h79;
            4'h4: return 7'h33; 4'h5: return 7'h5B; 4'h6: return 7'h5F; 4'h7: return 7'h70;
            4'h8: return 7'h7F; 4'h9: return 7'h7B; 4'hA: return 7'h77; 4'hB: return 7'h1F;
            4'hC: return 7'h4E; 4'hD: return 7'h3D; 4'hE: return 7'h4F; default: return 7'h47;
        endcase
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            sw_s1  <= switch;
            sw_s2  <= sw_s1;
            row_s1 <= btn_key_row;
            row_s2 <= row_s1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (adr)
            A_LED:   rd_data = 32'(led_r);
            A_RG0:   rd_data = {30'b0, rg0_r};
            A_RG1:   rd_data = {30'b0, rg1_r};
            A_NLO:   rd_data = num_lo;
            A_NHI:   rd_data = num_hi;
            A_BLK:   rd_data = 32'(blank_r);
            A_SW:    rd_data = 32'(sw_s2);
            A_KEY:   rd_data = key_rd;
            A_STP:   rd_data = {30'b0, step_r};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            if (req) wb_dat_o <= rd_data;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            led_r   <= '1;
            rg0_r   <= '0;
            rg1_r   <= '0;
            num_lo  <= '0;
            num_hi  <= '0;
            blank_r <= '0;
        end else if (wr) begin
            case (adr)
                A_LED:   led_r   <= LED_W'(merge(32'(led_r), wb_dat_i, wb_sel_i));
                A_RG0:   if (wb_sel_i[0]) rg0_r <= wb_dat_i[1:0];
                A_RG1:   if (wb_sel_i[0]) rg1_r <= wb_dat_i[1:0];
                A_NLO:   num_lo  <= merge(num_lo, wb_dat_i, wb_sel_i);
                A_NHI:   num_hi  <= merge(num_hi, wb_dat_i, wb_sel_i);
                A_BLK:   blank_r <= NUM_DIGITS'(merge(32'(blank_r), wb_dat_i, wb_sel_i));
                default: ;
            endcase
        end
    end

    // Step buttons: rising edge of the debounced level sets a sticky flag
    for (genvar g = 0; g < 2; g++) begin : g_step
        wb_io_dbnc #(.DEBOUNCE_W(DEBOUNCE_W)) u_dbnc (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .din      (btn_step[g]),
            .dout     (step_db[g])
        );
    end

    assign step_clr = (wr && adr == A_STP && wb_sel_i[0]) ? wb_dat_i[1:0] : 2'b00;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            step_db_q <= '0;
            step_r    <= '0;
        end else begin
            step_db_q <= step_db;
            step_r    <= (step_r & ~step_clr) | (step_db & ~step_db_q);
        end
    end

    // Display multiplexer; digit 0 shows the most significant used nibble
    logic [SCAN_DIV_W-1:0] div;
    logic [DIG_W-1:0]      dig, dig_rev;
    logic [63:0]           num_all;
    logic [5:0]            nib_base;

    assign tick     = &div;
    assign dig_rev  = DIG_W'(NUM_DIGITS - 1) - dig;
    assign num_all  = {num_hi, num_lo};
    assign nib_base = 6'({dig_rev, 2'b00});

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div     <= '0;
            dig     <= '0;
            num_csn <= '1;
            num_a_g <= '0;
        end else begin
            div <= div + 1'b1;
            if (tick) dig <= (dig == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig + 1'b1;
            num_csn <= blank_r[dig] ? '1 : ~(NUM_DIGITS'(1) << dig_rev);
            num_a_g <= seg7(num_all[nib_base +: 4]);
        end
    end

`ifdef IO_CTRL_KEYSCAN_EN
    typedef enum logic [1:0] {K_SCAN, K_HOLD, K_REL} kstate_t;

    kstate_t               ks, ks_nxt;
    logic [1:0]            col_idx, row_enc;
    logic [3:0]            cur_code, hold_code, key_code;
    logic [DEBOUNCE_W-1:0] kcnt;
    logic                  key_vld, row_any, cnt_done, key_latch, col_adv;

    always_comb begin
        row_enc = '0;
        for (int r = 3; r >= 0; r--) if (!row_s2[r]) row_enc = 2'(r);
    end

    assign row_any     = ~&row_s2;
    assign cur_code    = {row_enc, col_idx};
    assign cnt_done    = &kcnt;
    assign btn_key_col = ~(4'b0001 << col_idx);
    assign key_rd      = {23'b0, key_vld, 4'b0, key_code};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) ks <= K_SCAN;
        else          ks <= ks_nxt;
    end

    always_comb begin
        ks_nxt = ks;
        case (ks)
            K_SCAN:  if (row_any) ks_nxt = K_HOLD;
            K_HOLD:  if (!row_any) ks_nxt = K_SCAN;
                     else if (cnt_done && cur_code == hold_code) ks_nxt = K_REL;
            K_REL:   if (!row_any && cnt_done) ks_nxt = K_SCAN;
            default: ks_nxt = K_SCAN;
        endcase
    end

    always_comb begin
        key_latch = (ks == K_HOLD) && row_any && cnt_done && (cur_code == hold_code);
        col_adv   = (ks == K_SCAN) && tick && !row_any;
    end

    // A latch in the same cycle as a KEY read keeps valid set
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            col_idx   <= '0;
            hold_code <= '0;
            kcnt      <= '0;
            key_code  <= '0;
            key_vld   <= 1'b0;
        end else begin
            if (col_adv) col_idx <= col_idx + 1'b1;
            case (ks)
                K_SCAN: begin
                    kcnt      <= '0;
                    hold_code <= cur_code;
                end
                K_HOLD:
                    if (cur_code != hold_code || key_latch) begin
                        hold_code <= cur_code;
                        kcnt      <= '0;
                    end else kcnt <= kcnt + 1'b1;
                K_REL:   kcnt <= (row_any || cnt_done) ? '0 : kcnt + 1'b1;
                default: kcnt <= '0;
            endcase
            if (key_latch) begin
                key_code <= hold_code;
                key_vld  <= 1'b1;
            end else if (rd && adr == A_KEY) key_vld <= 1'b0;
        end
    end
`else
    assign btn_key_col = 4'b0000;
    assign key_rd      = {28'b0, row_s2};
`endif
endmodule

// File: tb/tb_wb_io_ctrl.sv
// Scoreboard bench for wb_io_ctrl: stimulus queues expectations, a monitor checks them.
module tb_wb_io_ctrl;
    localparam int K_RD = 0, K_WR = 1, K_ST = 2, K_TMO = 3;
    localparam logic [31:0] M_RST = 32'hF080FF7F, M_DSP = 32'h0000FF7F;
    localparam logic [31:0] W_CSN = 32'h0000FF00, W_AG = 32'h0000007F;
`ifdef IO_CTRL_KEYSCAN_EN
    localparam logic [31:0] RST_EXP = 32'hE000FF00;
`else
    localparam logic [31:0] RST_EXP = 32'h0000FF00;
`endif

    typedef struct {
        int          kind;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } sb_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_i = '0, dat_o;
    logic [3:0]  sel = '0, key_row, key_col;
    logic        ack;
    logic [15:0] led;
    logic [1:0]  rg0, rg1, step = 2'b00;
    logic [7:0]  csn, sw = 8'h5A;
    logic [6:0]  a_g;
    logic [31:0] st;
    sb_t         sb_q[$];
    sb_t         e;
    int          n_cmp = 0, n_bad = 0;
    bit          done = 1'b0;

    always #5 clk = ~clk;

`ifdef IO_CTRL_KEYSCAN_EN
    logic key_down = 1'b0;
    assign key_row = (key_down && !key_col[1]) ? 4'b1011 : 4'b1111;
`else
    logic [3:0] row_drv = 4'hF;
    assign key_row = row_drv;
`endif

    assign st = {key_col, 4'b0, ack, 7'b0, csn, 1'b0, a_g};

    wb_io_ctrl #(.NUM_DIGITS(8), .LED_W(16), .SW_W(8), .SCAN_DIV_W(2), .DEBOUNCE_W(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_dat_i    (dat_i),
        .wb_sel_i    (sel),
        .wb_dat_o    (dat_o),
        .wb_ack_o    (ack),
        .led         (led),
        .led_rg0     (rg0),
        .led_rg1     (rg1),
        .num_csn     (csn),
        .num_a_g     (a_g),
        .switch      (sw),
        .btn_key_row (key_row),
        .btn_key_col (key_col),
        .btn_step    (step)
    );

    function automatic sb_t mk(int k, logic [31:0] x, logic [31:0] m, string n);
        sb_t r;
        r.kind = k;
        r.exp  = x;
        r.mask = m;
        r.name = n;
        return r;
    endfunction

    // Monitor: status entries are checked at once, bus entries on each ack
    always @(negedge clk) begin
        if (sb_q.size() > 0 && (sb_q[0].kind == K_ST || sb_q[0].kind == K_TMO)) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (e.kind == K_TMO) begin
                n_bad++;
                $display("FAIL %s: no response within the cycle budget", e.name);
            end else if ((st & e.mask) !== (e.exp & e.mask)) begin
                n_bad++;
                $display("FAIL %s: got %08h want %08h (mask %08h)", e.name, st & e.mask,
                         e.exp & e.mask, e.mask);
            end
        end else if (ack && !rst) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_ack: got ack with dat %08h, want no ack", dat_o);
            end else begin
                e = sb_q.pop_front();
                if (e.kind == K_RD) begin
                    n_cmp++;
                    if (dat_o !== e.exp) begin
                        n_bad++;
                        $display("FAIL %s: got %08h want %08h", e.name, dat_o, e.exp);
                    end
                end
            end
        end
        if (done) begin
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: expectation never checked, got nothing want %08h", e.name, e.exp);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] x, input string nm);
        sb_q.push_back(mk(w ? K_WR : K_RD, x, '1, nm));
        cyc = 1'b1; stb = 1'b1; we = w; adr = {16'h0000, a}; dat_i = d; sel = s;
        for (int i = 0; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack) break;
            if (i == 20) begin
                sb_q.delete();
                sb_q.push_back(mk(K_TMO, '0, '0, nm));
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] x, input string nm);
        bus(1'b0, a, '0, 4'hF, x, nm);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        bus(1'b1, a, d, s, '0, "write");
    endtask

    // Wait until the watched fields match, then queue a full status expectation
    task automatic st_chk(input logic [31:0] wm, input logic [31:0] wv,
                          input logic [31:0] x, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i <= 100 && !hit; i++) begin
            if ((st & wm) == wv) begin
                sb_q.push_back(mk(K_ST, x, M_DSP, nm));
                hit = 1'b1;
            end else if (i == 100) begin
                sb_q.delete();
                sb_q.push_back(mk(K_TMO, '0, '0, nm));
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back(mk(K_ST, RST_EXP, M_RST, "reset_state"));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        rd(16'hF000, 32'h0000FFFF, "led_reset");
        wr(16'hF000, 32'h0000A5C3, 4'b0001);
        rd(16'hF000, 32'h0000FFC3, "led_byte0");
        wr(16'hF004, 32'hFFFFFFFE, 4'b1111);
        rd(16'hF004, 32'h00000002, "rg0_mask");
        wr(16'hF008, 32'h00000003, 4'b0000);
        rd(16'hF008, 32'h00000000, "rg1_no_lane");
        rd(16'hF020, 32'h0000005A, "switch");
        wr(16'hF020, 32'hFFFFFFFF, 4'b1111);
        rd(16'hF020, 32'h0000005A, "switch_ro");
        wr(16'hF030, 32'hFFFFFFFF, 4'b1111);
        rd(16'hF030, 32'h00000000, "unmapped");

        wr(16'hF010, 32'h12345678, 4'b0011);
        rd(16'hF010, 32'h00005678, "num_lo_half");
        st_chk(W_CSN, 32'h0000FE00, 32'h0000FE7F, "digit7_8");
        wr(16'hF010, 32'hA2345678, 4'b1111);
        st_chk(W_AG, 32'h00000077, 32'h00007F77, "digit0_A");
        st_chk(W_AG, 32'h0000006D, 32'h0000BF6D, "digit1_2");
        wr(16'hF018, 32'h00000001, 4'b1111);
        rd(16'hF018, 32'h00000001, "blank_rd");
        st_chk(W_AG, 32'h00000077, 32'h0000FF77, "digit0_blank");
        st_chk(W_CSN, 32'h0000FE00, 32'h0000FE7F, "digit7_unblanked");
        st_chk(W_AG, 32'h0000006D, 32'h0000BF6D, "digit1_unblanked");

        step = 2'b01;
        repeat (6) @(posedge clk);
        #1 step = 2'b00;
        repeat (40) @(posedge clk);
        #1 rd(16'hF028, 32'h00000000, "step_glitch");
        step = 2'b01;
        repeat (40) @(posedge clk);
        #1 step = 2'b00;
        repeat (40) @(posedge clk);
        #1 rd(16'hF028, 32'h00000001, "step0_press");
        wr(16'hF028, 32'h00000001, 4'b0001);
        rd(16'hF028, 32'h00000000, "step0_w1c");
        step = 2'b10;
        repeat (40) @(posedge clk);
        #1 step = 2'b00;
        repeat (40) @(posedge clk);
        #1 rd(16'hF028, 32'h00000002, "step1_press");
        wr(16'hF028, 32'h00000001, 4'b0001);
        rd(16'hF028, 32'h00000002, "step1_other_clr");
        wr(16'hF028, 32'h00000002, 4'b0001);
        rd(16'hF028, 32'h00000000, "step1_w1c");

`ifdef IO_CTRL_KEYSCAN_EN
        key_down = 1'b1;
        repeat (100) @(posedge clk);
        #1 rd(16'hF024, 32'h00000109, "key_latch");
        rd(16'hF024, 32'h00000009, "key_rd_clear");
        key_down = 1'b0;
        repeat (60) @(posedge clk);
        #1 rd(16'hF024, 32'h00000009, "key_no_relatch");
`else
        row_drv = 4'b1011;
        repeat (5) @(posedge clk);
        #1 rd(16'hF024, 32'h0000000B, "key_raw_rows");
        row_drv = 4'b1111;
        repeat (5) @(posedge clk);
        #1 rd(16'hF024, 32'h0000000F, "key_raw_idle");
`endif

        repeat (5) @(posedge clk);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach the summary, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
